divider_unit: RTL and testbench
===============================

// Module: divider_unit
// PURPOSE
//  Multi-cycle radix-2 integer divider serving the execute stage's DIV/DIVU/MOD/MODU (and W) ops.
//  Execute issues a request via valid/ready and stalls until the result handshake completes.
//  Result is written into execute_data_t.result by the execute stage.
//  One quotient bit per cycle; RISC-V M-extension semantics for divide-by-zero and overflow.
// PARAMETERS
//  XLEN  64  datapath width; word ops use the low XLEN/2 bits.
// PORTS
//  clk         in   1     clock, rising edge
//  resetn      in   1     asynchronous, active-low reset
//  flush       in   1     abort in-flight op (pipeline clear); synchronous
//  in_valid    in   1     request valid
//  in_ready    out  1     divider can accept (state IDLE)
//  in_op       in   1     divider_op_t: DIVOP=quotient, MODOP=remainder
//  in_signed   in   1     1=signed (DIV/MOD[W]), 0=unsigned (DIVU/MODU[W])
//  in_word     in   1     1=32-bit op, result sign-extended to XLEN
//  in_a        in   XLEN  dividend
//  in_b        in   XLEN  divisor
//  out_valid   out  1     result valid; held until out_ready
//  out_ready   in   1     consumer accepts result
//  out_result  out  XLEN  quotient or remainder
// BEHAVIOUR
//  Reset (resetn=0, async): state=IDLE, in_ready=1, out_valid=0, out_result=0, counter=0.
//  States: IDLE -> CALC -> DONE -> IDLE; IDLE -> DONE directly for special cases.
//  Accept: in_valid && in_ready in cycle 0; latch op, signed, word, operands.
//  Operand prep: word op -> use a[31:0], b[31:0], sign- or zero-extended per in_signed.
//   Signed -> take magnitudes; neg_q = sign(a)^sign(b) (b!=0), neg_r = sign(a).
//  Special cases, resolved at accept, next state DONE (out_valid in cycle 1):
//   b==0: quotient = all ones (-1), remainder = a (word: low 32 of a, sign-extended).
//   signed, a==MIN, b==-1 (MIN = 1<<(N-1) of effective width N): quotient = MIN, remainder = 0.
//  CALC: restoring division, N = 32 (word) or XLEN; counter loaded with N.
//   Each cycle: rem = {rem, quo[msb]}; shift quo left; if rem >= divisor: rem -= divisor, quo[0]=1.
//   Counter decrements per step; after the N-th step state=DONE.
//   Normal latency: out_valid first high in cycle N+1 (33 word, 65 doubleword).
//  DONE: out_result = sign-fixed quotient (DIVOP) or remainder (MODOP);
//   word op: result[31:0] sign-extended to XLEN (also for unsigned W ops).
//   out_valid=1, stable until out_ready; on out_valid&&out_ready -> IDLE, out_valid=0 next cycle.
//   No back-to-back overlap: in_ready=0 in CALC and DONE; new request accepted earliest the cycle after the out handshake.
//  flush: highest priority after reset; from any state -> IDLE next cycle, out_valid=0, no result issued.
//   flush && in_valid in IDLE: request is dropped, not accepted.
//  in_* ignored outside IDLE; out_result is a don't-care when out_valid=0 (drive 0 in IDLE).
//  Reset asserted mid-CALC: immediate return to reset values; no partial result is ever output.
// TESTING
//  DIVOP signed dw: a=-7, b=2 -> out_valid in cycle 65, result=-3 (0xFFFF_FFFF_FFFF_FFFD).
//  MODOP signed dw: a=-7, b=2 -> result=-1; MODOP unsigned: a=100, b=7 -> result=2.
//  DIVOP unsigned word: a=0x0000_0000_8000_0000, b=1 -> result=0xFFFF_FFFF_8000_0000, cycle 33.
//  b=0: DIVOP a=5 -> 0xFFFF_FFFF_FFFF_FFFF; MODOP a=5 -> 5; both out_valid in cycle 1.
//  Overflow: signed DIVOP a=0x8000_0000_0000_0000, b=-1 -> same value; MODOP -> 0; cycle 1.
//  Stall then flush: hold out_ready=0 five cycles -> result stable; separately flush in cycle 10 of CALC
//   -> IDLE next cycle, in_ready=1, out_valid never asserted; resetn pulse mid-CALC -> all outputs at reset values.

Source files
------------

// File: rtl/divider_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU and their W forms.
// One quotient bit per cycle; divide-by-zero and signed overflow resolve at accept.

module divider_step #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] dvs,
  output logic [XLEN-1:0] rem_nx,
  output logic [XLEN-1:0] quo_nx
);
  logic [XLEN:0] sh;
  logic [XLEN:0] diff;
  logic          ge;

  // rem < dvs on entry, so the XLEN+1-bit difference's top bit is a clean borrow
  always_comb begin
    sh     = {rem, quo[XLEN-1]};
    diff   = sh - {1'b0, dvs};
    ge     = ~diff[XLEN];
    rem_nx = ge ? diff[XLEN-1:0] : sh[XLEN-1:0];
    quo_nx = {quo[XLEN-2:0], ge};
  end
endmodule

module divider_unit #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_op,
  input  logic            in_signed,
  input  logic            in_word,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result
);
  localparam int HW = XLEN / 2;
  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  typedef enum logic {DIVOP = 1'b0, MODOP = 1'b1} divider_op_t;

  typedef struct packed {
    logic op;
    logic word;
    logic neg_q;
    logic neg_r;
  } div_ctl_t;

  state_t          state;
  div_ctl_t        ctl;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] rem_q, quo_q, dvs_q;
  logic [XLEN-1:0] rem_nx, quo_nx;

  logic [XLEN-1:0] ea, eb, mag_a, mag_b, min_val, quo_init;
  logic [XLEN-1:0] spec_res, q_fix, r_fix, calc_res;
  logic            sa, sb, b_zero, ovf;

  function automatic logic [XLEN-1:0] wfix(input logic [XLEN-1:0] v, input logic w);
    return w ? {{HW{v[HW-1]}}, v[HW-1:0]} : v;
  endfunction

  // Operand prep and special-case detection on the incoming request
  always_comb begin
    if (in_word) begin
      ea = {{HW{in_signed & in_a[HW-1]}}, in_a[HW-1:0]};
      eb = {{HW{in_signed & in_b[HW-1]}}, in_b[HW-1:0]};
    end else begin
      ea = in_a;
      eb = in_b;
    end
    sa      = in_signed & ea[XLEN-1];
    sb      = in_signed & eb[XLEN-1];
    mag_a   = sa ? -ea : ea;
    mag_b   = sb ? -eb : eb;
    min_val = in_word ? {{HW{1'b1}}, 1'b1, {(HW-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
    b_zero  = (eb == '0);
    ovf     = in_signed & (ea == min_val) & (eb == '1);
    // Word dividends sit in the upper half so the step always shifts from bit XLEN-1
    quo_init = in_word ? {mag_a[HW-1:0], {HW{1'b0}}} : mag_a;
    if (in_op == MODOP)
      spec_res = b_zero ? ea : '0;
    else
      spec_res = b_zero ? '1 : ea;
  end

  divider_step #(.XLEN(XLEN)) u_step (
    .rem    (rem_q),
    .quo    (quo_q),
    .dvs    (dvs_q),
    .rem_nx (rem_nx),
    .quo_nx (quo_nx)
  );

  always_comb begin
    q_fix    = ctl.neg_q ? -quo_nx : quo_nx;
    r_fix    = ctl.neg_r ? -rem_nx : rem_nx;
    calc_res = wfix((ctl.op == MODOP) ? r_fix : q_fix, ctl.word);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_result <= '0;
      cnt        <= '0;
      ctl        <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
    end else if (flush) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_result <= '0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready  <= 1'b0;
            ctl.op    <= in_op;
            ctl.word  <= in_word;
            ctl.neg_q <= sa ^ sb;
            ctl.neg_r <= sa;
            if (b_zero || ovf) begin
              state      <= DONE;
              out_valid  <= 1'b1;
              out_result <= wfix(spec_res, in_word);
            end else begin
              state <= CALC;
              cnt   <= in_word ? CW'(HW) : CW'(XLEN);
              rem_q <= '0;
              quo_q <= quo_init;
              dvs_q <= mag_b;
            end
          end
        end
        CALC: begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          cnt   <= cnt - CW'(1);
          // Last step: publish the sign-fixed result in the same edge
          if (cnt == CW'(1)) begin
            state      <= DONE;
            out_valid  <= 1'b1;
            out_result <= calc_res;
          end
        end
        DONE: begin
          if (out_ready) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_result <= '0;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_divider_unit.sv
// Directed bench for divider_unit: results, latency, special cases, stall, flush, reset.

module tb_divider_unit;
  localparam int   XLEN  = 64;
  localparam logic DIVOP = 1'b0;
  localparam logic MODOP = 1'b1;

  logic            clk, resetn, flush;
  logic            in_valid, in_ready, in_op, in_signed, in_word;
  logic [XLEN-1:0] in_a, in_b;
  logic            out_valid, out_ready;
  logic [XLEN-1:0] out_result;

  int n_chk = 0;
  int n_err = 0;

  divider_unit #(.XLEN(XLEN)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_signed  (in_signed),
    .in_word    (in_word),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts and ends 1 time unit after a rising edge; returns in cycle 1
  task automatic issue(input logic op, input logic sgn, input logic word,
                       input logic [63:0] a, input logic [63:0] b);
    in_op = op; in_signed = sgn; in_word = word; in_a = a; in_b = b;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic op, input logic sgn, input logic word,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp,
                        input int exp_lat, input int stall);
    int lat;
    issue(op, sgn, word, a, b);
    lat = 1;
    if (exp_lat > 1) chk({tag, "_busy"}, 64'(in_ready), 64'd0);
    while (!out_valid && lat < 200) begin
      step();
      lat++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_res"}, out_result, exp);
    for (int i = 0; i < stall; i++) begin
      step();
      chk({tag, "_hold_vld"}, 64'(out_valid), 64'd1);
      chk({tag, "_hold_res"}, out_result, exp);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_ack"}, 64'({out_valid, in_ready}), 64'b01);
  endtask

  initial begin
    logic seen;
    resetn = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_valid = 1'b0; in_op = 1'b0; in_signed = 1'b0; in_word = 1'b0;
    in_a = '0; in_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_result", out_result, 64'd0);
    resetn = 1'b1;
    step();

    run_op("divs_m7_2",  DIVOP, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, 0);
    run_op("mods_m7_2",  MODOP, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 0);
    run_op("modu_100_7", MODOP, 1'b0, 1'b0, 64'd100, 64'd7, 64'd2, 65, 0);
    run_op("divs_7_m2",  DIVOP, 1'b1, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 65, 0);
    run_op("mods_7_m2",  MODOP, 1'b1, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 65, 0);
    run_op("divu_big",   DIVOP, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'h0FFF_FFFF_FFFF_FFFF, 65, 0);
    run_op("modu_big",   MODOP, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'hF, 65, 0);
    run_op("divuw_msb",  DIVOP, 1'b0, 1'b1, 64'h0000_0000_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 33, 0);
    run_op("divuw_half", DIVOP, 1'b0, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd2, 64'h0000_0000_7FFF_FFFF, 33, 0);
    run_op("divw_m20_3", DIVOP, 1'b1, 1'b1, 64'h1234_5678_FFFF_FFEC, 64'hDEAD_0000_0000_0003, 64'hFFFF_FFFF_FFFF_FFFA, 33, 0);
    run_op("modw_m20_3", MODOP, 1'b1, 1'b1, 64'h1234_5678_FFFF_FFEC, 64'hDEAD_0000_0000_0003, 64'hFFFF_FFFF_FFFF_FFFE, 33, 0);

    run_op("div_by0",    DIVOP, 1'b0, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
    run_op("mod_by0",    MODOP, 1'b0, 1'b0, 64'd5, 64'd0, 64'd5, 1, 0);
    run_op("divuw_by0",  DIVOP, 1'b0, 1'b1, 64'hABCD_0000_0000_0007, 64'h1_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
    run_op("moduw_by0",  MODOP, 1'b0, 1'b1, 64'hABCD_0000_0000_0007, 64'h1_0000_0000, 64'd7, 1, 0);
    run_op("div_ovf",    DIVOP, 1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1, 0);
    run_op("mod_ovf",    MODOP, 1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1, 0);
    run_op("divw_ovf",   DIVOP, 1'b1, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1, 0);
    run_op("modw_ovf",   MODOP, 1'b1, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'd0, 1, 0);

    // Consumer stalls five cycles; result must hold
    run_op("stall",      DIVOP, 1'b0, 1'b0, 64'd1000, 64'd7, 64'd142, 65, 5);

    // Flush in cycle 10 of CALC
    issue(DIVOP, 1'b0, 1'b0, 64'd1000, 64'd7);
    seen = 1'b0;
    for (int i = 0; i < 9; i++) begin
      seen |= out_valid;
      step();
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_ready", 64'(in_ready), 64'd1);
    chk("flush_valid", 64'(out_valid), 64'd0);
    for (int i = 0; i < 70; i++) begin
      seen |= out_valid;
      step();
    end
    chk("flush_no_result", 64'(seen), 64'd0);

    // Flush together with a request in IDLE drops the request
    in_op = DIVOP; in_signed = 1'b0; in_word = 1'b0; in_a = 64'd9; in_b = 64'd3;
    in_valid = 1'b1; flush = 1'b1;
    step();
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_drop_ready", 64'(in_ready), 64'd1);
    step();
    step();
    chk("flush_drop_valid", 64'(out_valid), 64'd0);

    // Reset pulse mid-CALC
    issue(DIVOP, 1'b1, 1'b0, 64'd77, 64'd5);
    repeat (5) step();
    resetn = 1'b0;
    #1;
    chk("midrst_ready", 64'(in_ready), 64'd1);
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_result", out_result, 64'd0);
    step();
    resetn = 1'b1;
    step();
    run_op("post_rst",   DIVOP, 1'b1, 1'b0, 64'd77, 64'd5, 64'd15, 65, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
